// File: rtl/muldiv_sequencer.sv
// Control sequencer for the shared iterative multiply/divide datapath.
// Runs operand load, ITER step cycles and HI/LO writeback; flags divide-by-zero.
module muldiv_sequencer #(
    parameter int ITER  = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [31:0]      divisor,
    output logic             mloadab,
    output logic             mult,
    output logic             dloadab,
    output logic             div,
    output logic             muxhigh,
    output logic             muxlow,
    output logic             highwrite,
    output logic             lowwrite,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [CNT_W-1:0] iter_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MLOAD,
        S_MRUN,
        S_DLOAD,
        S_DRUN,
        S_WB,
        S_DZERO
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic             op_q, op_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        count_d = count_q;
        unique case (state_q)
            S_IDLE: begin
                // MULT wins when both starts arrive together
                if (start_mult) begin
                    state_d = S_MLOAD;
                    op_d    = 1'b0;
                end else if (start_div) begin
                    if (divisor != 32'd0) begin
                        state_d = S_DLOAD;
                        op_d    = 1'b1;
                    end else begin
                        state_d = S_DZERO;
                    end
                end
            end
            S_MLOAD: begin
                count_d = '0;
                state_d = S_MRUN;
            end
            S_DLOAD: begin
                count_d = '0;
                state_d = S_DRUN;
            end
            S_MRUN, S_DRUN: begin
                if (count_q == LAST) begin
                    count_d = '0;
                    state_d = S_WB;
                end else begin
                    count_d = count_q + ONE;
                end
            end
            S_WB:    state_d = S_IDLE;
            S_DZERO: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mloadab    = 1'b0;
        mult       = 1'b0;
        dloadab    = 1'b0;
        div        = 1'b0;
        muxhigh    = 1'b0;
        muxlow     = 1'b0;
        highwrite  = 1'b0;
        lowwrite   = 1'b0;
        done       = 1'b0;
        divzero    = 1'b0;
        iter_count = '0;
        busy       = (state_q != S_IDLE);
        unique case (state_q)
            S_MLOAD: mloadab = 1'b1;
            S_DLOAD: dloadab = 1'b1;
            S_MRUN: begin
                mult       = 1'b1;
                iter_count = count_q;
            end
            S_DRUN: begin
                div        = 1'b1;
                iter_count = count_q;
            end
            S_WB: begin
                highwrite = 1'b1;
                lowwrite  = 1'b1;
                muxhigh   = op_q;
                muxlow    = op_q;
                done      = 1'b1;
            end
            S_DZERO: divzero = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Control sequencer for the shared iterative multiply/divide datapath: runs the operand-load, iterate and HI/LO writeback phases of MULT and DIV.
- Raises the divide-by-zero exception request.
- Sits between the main control FSM (which issues start pulses and waits on done/divzero) and the mult/div units plus the HI/LO registers and their input muxes.

Parameters:
- ITER, 32, number of iteration cycles per operation (one per operand bit).
- CNT_W, 6, iteration counter width; must hold ITER.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- start_mult  input  1  request MULT; sampled only in IDLE.
- start_div  input  1  request DIV; sampled only in IDLE.
- divisor  input  32  divisor operand (B register value); checked for zero when start_div is sampled.
- mloadab  output  1  load multiplier operand registers.
- mult  output  1  multiplier iteration-step enable.
- dloadab  output  1  load divider operand registers.
- div  output  1  divider iteration-step enable.
- muxhigh  output  1  HI input select: 0 = multiplier result, 1 = divider result.
- muxlow  output  1  LO input select: 0 = multiplier result, 1 = divider result.
- highwrite  output  1  HI register load.
- lowwrite  output  1  LO register load.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse, result committed.
- divzero  output  1  one-cycle pulse, divide-by-zero exception request.
- iter_count  output  CNT_W  current iteration index.

Behaviour:
- The FSM uses one clock and a synchronous active-high reset. All outputs are Moore-decoded from registered state, op flag and counter.
- States: IDLE, M_LOAD, M_RUN, D_LOAD, D_RUN, WRITEBACK, DZERO.
- Reset: state=IDLE, count=0, op=0. Every output is 0 in IDLE.

Transitions out of IDLE:
- start_mult=1 -> M_LOAD, op<=0. start_mult has priority when both starts are high.
- start_div=1 and divisor!=0 -> D_LOAD, op<=1.
- start_div=1 and divisor==0 -> DZERO.
- Otherwise remain in IDLE.

Other states:
- M_LOAD / D_LOAD: held 1 cycle. Asserts mloadab / dloadab and sets count<=0. Next state is M_RUN / D_RUN.
- M_RUN / D_RUN: asserts mult / div every cycle. iter_count=count, and count increments each cycle.
  - When count==ITER-1, next state is WRITEBACK.
  - Exactly ITER step cycles occur.
- WRITEBACK: held 1 cycle. Asserts highwrite=lowwrite=1, muxhigh=muxlow=op, done=1. Next state is IDLE.
- DZERO: held 1 cycle. Asserts divzero=1; no load, step or HI/LO write occurs. Next state is IDLE.

Output rules:
- busy=1 in every state except IDLE.
- muxhigh/muxlow are 0 outside WRITEBACK.
- iter_count is 0 outside RUN states.

Timing:
- With start sampled at the edge ending cycle 0: LOAD is cycle 1, RUN is cycles 2..ITER+1, WRITEBACK is cycle ITER+2.
- The earliest next accepted start is sampled in cycle ITER+3.

Boundary conditions:
- Starts asserted while busy (including during WRITEBACK or DZERO) are ignored, not queued.
- The divisor is examined only at the start_div sample edge. Later changes have no effect.
- Reset asserted in any state: IDLE on the next edge with all outputs 0. No HI/LO write, done or divzero occurs for the aborted op. Reset has priority over start in the same cycle.
- Count arithmetic is unsigned CNT_W bits and never wraps, because the RUN exit occurs at ITER-1.

Test Plan:
1. Reset, then start_mult pulse in cycle 0.
   - mloadab=1 in cycle 1 only.
   - mult=1 in cycles 2..33, with iter_count 0..31.
   - Cycle 34: highwrite=lowwrite=done=1, muxhigh=muxlow=0.
   - busy=1 in cycles 1..34; IDLE in cycle 35.
2. start_div with divisor=7 in cycle 0.
   - dloadab in cycle 1, div in cycles 2..33.
   - Cycle 34: highwrite=lowwrite=done=1, muxhigh=muxlow=1.
   - mloadab and mult stay 0 throughout.
3. start_div with divisor=0 in cycle 0.
   - divzero=1 and busy=1 in cycle 1 only.
   - dloadab, div, highwrite, lowwrite and done are never asserted.
   - IDLE in cycle 2; a start_mult in cycle 2 is accepted.
4. start_mult and start_div both high in cycle 0, then start_div held high in cycles 10..40.
   - A single MULT sequence runs (done in cycle 34, muxhigh=0).
   - The DIV is accepted only at the cycle-35 sample: dloadab in cycle 36.
5. start_mult in cycle 0, then Reset=1 in cycle 20.
   - Cycle 21: every output 0, iter_count=0.
   - highwrite and done are never pulsed for this op.
   - start_mult in cycle 21 gives mloadab in cycle 22.
6. Instance with ITER=4, CNT_W=3, start_mult in cycle 0.
   - mult=1 in cycles 2..5, with iter_count 0..3.
   - done and highwrite in cycle 6; busy=0 in cycle 7.
